// File: rtl/pyrm_wb_pkg.sv
// Shared types and constants for the pyrm write-back / LSU stage.
// Opcode and funct3 encodings follow the RV64 base ISA (rv64.vh values).
package pyrm_wb_pkg;

  localparam int unsigned PYRM_XLEN  = 64;
  localparam int unsigned PYRM_REG_W = 5;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_I   = 7'b0010011;
  localparam logic [6:0] OP_64ARITH   = 7'b0111011;
  localparam logic [6:0] OP_64ARITH_I = 7'b0011011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2,
    OUT_HOLD = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [31:0]           inst;
    logic [PYRM_XLEN-1:0]  pc;
    logic [PYRM_XLEN-1:0]  addr;
    logic [PYRM_XLEN-1:0]  data;
  } lsu_req_t;

  typedef struct packed {
    logic [PYRM_REG_W-1:0] rd;
    logic [PYRM_XLEN-1:0]  data;
  } wb_out_t;

  // Low address bits that must be zero for a naturally aligned access of 2^sz bytes.
  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/pyrm_wb_lsu_stage_dcache.sv
// Local data cache: synchronous dual-line read (idx, idx+1 wrapping) with
// one-cycle latency and independent write enables for the two lines.
module pyrm_wb_dcache_dual #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned IDX_W = 11
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [XLEN-1:0]  rd_data0,
  output logic [XLEN-1:0]  rd_data1,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_en0,
  input  logic             wr_en1,
  input  logic [XLEN-1:0]  wr_data0,
  input  logic [XLEN-1:0]  wr_data1
);

  logic [XLEN-1:0]  mem_q [0:(1<<IDX_W)-1];
  logic [XLEN-1:0]  rd_data0_q, rd_data1_q;
  logic [IDX_W-1:0] rd_idx_p1, wr_idx_p1;

  // Truncation to IDX_W bits makes the last line pair with line 0.
  assign rd_idx_p1 = rd_idx + {{(IDX_W-1){1'b0}}, 1'b1};
  assign wr_idx_p1 = wr_idx + {{(IDX_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (wr_en0) mem_q[wr_idx]    <= wr_data0;
    if (wr_en1) mem_q[wr_idx_p1] <= wr_data1;
    if (rd_en) begin
      rd_data0_q <= mem_q[rd_idx];
      rd_data1_q <= mem_q[rd_idx_p1];
    end
  end

  assign rd_data0 = rd_data0_q;
  assign rd_data1 = rd_data1_q;

endmodule

// File: rtl/pyrm_wb_lsu_stage.sv
// pyrm write-back / memory stage: loads, stores (line-crossing capable) and
// result forwarding. Optional macro PYRM_WB_LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module pyrm_wb_lsu_stage
  import pyrm_wb_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DC_IDX_W = 11,
  parameter int unsigned REG_W    = 5
) (
  input  logic             clk,
  input  logic             reset_pyri,
  input  logic [31:0]      inst_pyri,
  input  logic [XLEN-1:0]  pc_pyri,
  input  logic [XLEN-1:0]  addr_pyri,
  input  logic [XLEN-1:0]  data_pyri,
  input  logic [XLEN-1:0]  branch_pc_pyri,
  input  logic             branch_taken_pyri,
  input  logic             in_valid_pyri,
  output logic             in_retry_pyro,
  output logic [REG_W-1:0] decode_reg_addr_pyro,
  output logic [XLEN-1:0]  decode_reg_data_pyro,
  output logic             decode_reg_valid_pyro,
  input  logic             decode_reg_retry_pyri,
  output logic [REG_W-1:0] debug_reg_addr_pyro,
  output logic [XLEN-1:0]  debug_reg_data_pyro,
  output logic             debug_reg_valid_pyro,
  input  logic             debug_reg_retry_pyri,
`ifdef PYRM_WB_LSU_MISALIGN_TRAP_EN
  output logic             misalign_trap_pyro,
  output logic [XLEN-1:0]  misalign_pc_pyro,
`endif
  output logic [XLEN-1:0]  branch_pc_pyro,
  output logic             branch_pc_valid_pyro,
  input  logic             branch_pc_retry_pyri
);

  wb_state_e         state_q, state_d;
  lsu_req_t          req_q, req_d;
  wb_out_t           wb_q, wb_d;
  logic              dec_v_q, dec_v_d, dbg_v_q, dbg_v_d, br_v_q, br_v_d;
  logic [XLEN-1:0]   br_pc_q, br_pc_d;
  logic [XLEN-1:0]   line0_q, line0_d, line1_q, line1_d;
  logic              lo_we_q, lo_we_d, hi_we_q, hi_we_d;

  logic [6:0]        op_in, op_req;
  logic [2:0]        f3_req;
  logic              is_arith_in, is_jump_in, is_mem_in, mem_trap;
  logic              exit_ok, accept, rd_en;
  logic [XLEN-1:0]   rd_data0, rd_data1, ld_val, mask_lo;
  logic [5:0]        sh;
  logic [2*XLEN-1:0] pair, pair_sh, mask_pair, data_pair, merged;

  assign op_in       = inst_pyri[6:0];
  assign op_req      = req_q.inst[6:0];
  assign f3_req      = req_q.inst[14:12];
  assign is_arith_in = (op_in == OP_ARITH) || (op_in == OP_ARITH_I) || (op_in == OP_64ARITH) ||
                       (op_in == OP_64ARITH_I) || (op_in == OP_LUI) || (op_in == OP_AUIPC) ||
                       (op_in == OP_JAL) || (op_in == OP_JALR);
  assign is_jump_in  = (op_in == OP_JAL) || (op_in == OP_JALR) || (op_in == OP_BRANCH);
  assign is_mem_in   = (op_in == OP_LOAD) || (op_in == OP_STORE);

`ifdef PYRM_WB_LSU_MISALIGN_TRAP_EN
  assign mem_trap = is_mem_in && ((addr_pyri[2:0] & size_mask(inst_pyri[13:12])) != 3'b000);
`else
  assign mem_trap = 1'b0;
`endif

  // Every channel still pending must see retry=0 for the stage to free up this cycle.
  assign exit_ok       = (!dec_v_q || !decode_reg_retry_pyri) &&
                         (!dbg_v_q || !debug_reg_retry_pyri) &&
                         (!br_v_q  || !branch_pc_retry_pyri);
  assign in_retry_pyro = !((state_q == IDLE) || ((state_q == OUT_HOLD) && exit_ok));
  assign accept        = in_valid_pyri && !in_retry_pyro;

  // Byte-lane alignment over the two-line window returned by the cache.
  always_comb begin
    pair      = {rd_data1, rd_data0};
    sh        = {req_q.addr[2:0], 3'b000};
    pair_sh   = pair >> sh;
    case (f3_req)
      F3_B:    ld_val = {{(XLEN-8){pair_sh[7]}}, pair_sh[7:0]};
      F3_H:    ld_val = {{(XLEN-16){pair_sh[15]}}, pair_sh[15:0]};
      F3_W:    ld_val = {{(XLEN-32){pair_sh[31]}}, pair_sh[31:0]};
      F3_D:    ld_val = pair_sh[XLEN-1:0];
      F3_BU:   ld_val = {{(XLEN-8){1'b0}}, pair_sh[7:0]};
      F3_HU:   ld_val = {{(XLEN-16){1'b0}}, pair_sh[15:0]};
      F3_WU:   ld_val = {{(XLEN-32){1'b0}}, pair_sh[31:0]};
      default: ld_val = '0;
    endcase
    case (f3_req[1:0])
      2'b00:   mask_lo = {{(XLEN-8){1'b0}}, 8'hFF};
      2'b01:   mask_lo = {{(XLEN-16){1'b0}}, 16'hFFFF};
      2'b10:   mask_lo = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      default: mask_lo = '1;
    endcase
    mask_pair = {{XLEN{1'b0}}, mask_lo} << sh;
    data_pair = {{XLEN{1'b0}}, req_q.data & mask_lo} << sh;
    merged    = (pair & ~mask_pair) | data_pair;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wb_d    = wb_q;
    br_pc_d = br_pc_q;
    dec_v_d = dec_v_q && decode_reg_retry_pyri;
    dbg_v_d = dbg_v_q && debug_reg_retry_pyri;
    br_v_d  = br_v_q && branch_pc_retry_pyri;
    line0_d = line0_q;
    line1_d = line1_q;
    lo_we_d = lo_we_q;
    hi_we_d = hi_we_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE, OUT_HOLD: begin
        if (state_q == OUT_HOLD && exit_ok) state_d = IDLE;
        if (accept) begin
          if (is_mem_in) begin
            if (!mem_trap) begin
              req_d   = '{inst: inst_pyri, pc: pc_pyri, addr: addr_pyri, data: data_pyri};
              rd_en   = 1'b1;
              state_d = MEM_RD;
            end
          end else begin
            if (is_arith_in && inst_pyri[11:7] != '0) begin
              wb_d    = '{rd: inst_pyri[11:7], data: data_pyri};
              dec_v_d = 1'b1;
              dbg_v_d = 1'b1;
              state_d = OUT_HOLD;
            end
            if (is_jump_in && branch_taken_pyri) begin
              br_pc_d = branch_pc_pyri;
              br_v_d  = 1'b1;
              state_d = OUT_HOLD;
            end
          end
        end
      end
      MEM_RD: begin
        if (op_req == OP_LOAD) begin
          wb_d    = '{rd: req_q.inst[11:7], data: ld_val};
          dec_v_d = 1'b1;
          dbg_v_d = 1'b1;
          state_d = OUT_HOLD;
        end else begin
          {line1_d, line0_d} = merged;
          lo_we_d = !f3_req[2];
          hi_we_d = !f3_req[2] && (mask_pair[2*XLEN-1:XLEN] != '0);
          state_d = MEM_WR;
        end
      end
      MEM_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    req_q   <= req_d;
    wb_q    <= wb_d;
    br_pc_q <= br_pc_d;
    line0_q <= line0_d;
    line1_q <= line1_d;
    lo_we_q <= lo_we_d;
    hi_we_q <= hi_we_d;
    if (reset_pyri) begin
      state_q <= IDLE;
      dec_v_q <= 1'b0;
      dbg_v_q <= 1'b0;
      br_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_v_q <= dec_v_d;
      dbg_v_q <= dbg_v_d;
      br_v_q  <= br_v_d;
    end
  end

`ifdef PYRM_WB_LSU_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] mpc_q, mpc_d;

  always_comb begin
    trap_d = accept && mem_trap;
    mpc_d  = trap_d ? pc_pyri : mpc_q;
  end

  always_ff @(posedge clk) begin
    if (reset_pyri) begin
      trap_q <= 1'b0;
      mpc_q  <= '0;
    end else begin
      trap_q <= trap_d;
      mpc_q  <= mpc_d;
    end
  end

  assign misalign_trap_pyro = trap_q;
  assign misalign_pc_pyro   = mpc_q;
`endif

  pyrm_wb_dcache_dual #(
    .XLEN  (XLEN),
    .IDX_W (DC_IDX_W)
  ) u_dcache (
    .clk      (clk),
    .rd_en    (rd_en),
    .rd_idx   (addr_pyri[DC_IDX_W+2:3]),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .wr_idx   (req_q.addr[DC_IDX_W+2:3]),
    .wr_en0   ((state_q == MEM_WR) && lo_we_q && !reset_pyri),
    .wr_en1   ((state_q == MEM_WR) && hi_we_q && !reset_pyri),
    .wr_data0 (line0_q),
    .wr_data1 (line1_q)
  );

  assign decode_reg_addr_pyro  = wb_q.rd;
  assign decode_reg_data_pyro  = wb_q.data;
  assign decode_reg_valid_pyro = dec_v_q;
  assign debug_reg_addr_pyro   = wb_q.rd;
  assign debug_reg_data_pyro   = wb_q.data;
  assign debug_reg_valid_pyro  = dbg_v_q;
  assign branch_pc_pyro        = br_pc_q;
  assign branch_pc_valid_pyro  = br_v_q;

  logic unused_bits;
  assign unused_bits = ^{req_q.pc, req_q.inst, req_q.addr, pc_pyri, pair_sh[2*XLEN-1:XLEN]};

endmodule

// File: doc/pyrm_wb_lsu_stage.md
Name: pyrm_wb_lsu_stage

Overview:
- Parametrised write-back/memory stage of the pyrm RISC-V pipeline; sits after execute and feeds the decode register file and the debug port.
- Performs RV64 loads and stores (B/H/W/D, signed and unsigned) against a local data cache, including accesses that cross a line boundary.
- Passes ALU/JAL/JALR results and branch targets through a registered output with valid/retry handshakes.

Parameters:
- XLEN, 64, datapath and address width.
- DC_IDX_W, 11, data-cache line index width (2^DC_IDX_W lines of XLEN bits).
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- reset_pyri  in  1  synchronous active-high reset
- inst_pyri  in  32  instruction (opcode, funct3, rd)
- pc_pyri  in  XLEN  instruction pc
- addr_pyri  in  XLEN  effective byte address (load/store)
- data_pyri  in  XLEN  store data or ALU/link result
- branch_pc_pyri  in  XLEN  resolved branch/jump target
- branch_taken_pyri  in  1  branch_pc_pyri is a redirect
- in_valid_pyri  in  1  input bundle valid
- in_retry_pyro  out  1  stage cannot accept the bundle this cycle
- decode_reg_addr_pyro  out  REG_W  writeback rd to decode
- decode_reg_data_pyro  out  XLEN  writeback value to decode
- decode_reg_valid_pyro  out  1
- decode_reg_retry_pyri  in  1
- debug_reg_addr_pyro  out  REG_W  same rd, debug copy
- debug_reg_data_pyro  out  XLEN
- debug_reg_valid_pyro  out  1
- debug_reg_retry_pyri  in  1
- branch_pc_pyro  out  XLEN  redirect target
- branch_pc_valid_pyro  out  1
- branch_pc_retry_pyri  in  1

Behaviour:
- Handshake: a transfer occurs on a cycle with valid=1 and retry=0. Outputs hold stable while valid=1 and retry=1.
- Reset: FSM returns to IDLE and all *_valid_pyro go to 0. Per-consumer accepted bits clear; in_retry_pyro=0. Cache contents are not reset.
- Reset takes priority over everything, including a pending cache write.
- FSM states: IDLE, MEM_RD, MEM_WR, OUT_HOLD.
- IDLE:
  - Arithmetic ops (ARITH, ARITH_I, 64ARITH, 64ARITH_I, LUI, AUIPC, JAL, JALR) with rd!=0 load the output register: rd, data_pyri. Go to OUT_HOLD. Latency is 1 cycle.
  - Branches, and JAL/JALR with branch_taken_pyri, also load branch_pc_pyro.
  - LOAD/STORE: latch the bundle, issue a cache read of lines idx=addr[DC_IDX_W+2:3] and idx+1, go to MEM_RD.
  - An instruction with no output (rd=0 arithmetic, non-taken branch) is accepted and dropped, staying in IDLE.
- MEM_RD (read data valid):
  - LOAD: shift the line pair right by addr[2:0] bytes, select and extend by funct3, load the output register, go to OUT_HOLD. Load latency is 2 cycles.
  - STORE: merge the size bytes of data_pyri into the line pair at byte offset addr[2:0], go to MEM_WR.
- MEM_WR: write line idx, plus line idx+1 only when offset+size>8. Return to IDLE; stores produce no writeback.
- Line-crossing index idx+1 wraps modulo 2^DC_IDX_W (last line pairs with line 0).
- OUT_HOLD:
  - decode and debug channels are independent; each has an accepted bit.
  - Each channel's valid drops after its own transfer.
  - Leave to IDLE when all pending channels, including branch_pc, have transferred.
  - On the exit cycle, a new bundle may be accepted: in_retry_pyro=0 if every remaining valid sees retry=0 this cycle.
- in_retry_pyro=1 in MEM_RD and MEM_WR, and in OUT_HOLD except on the exit cycle.
- Unknown opcodes are accepted and dropped. An unsupported funct3 gives load data 0, and a store of that kind writes nothing.

Optional Feature:
- Macro: PYRM_WB_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_trap_pyro (1 bit, valid-only pulse) and misalign_pc_pyro (XLEN).
  - Any load/store with addr not naturally aligned to its size skips the cache and produces no writeback.
  - It pulses the trap for 1 cycle with pc_pyri, then stays in IDLE.
- Undefined: misaligned and line-crossing accesses complete as split accesses as above.

Decomposition:
- Package pyrm_wb_pkg holds:
  - opcode and funct3 constants (reuse the rv64.vh values);
  - the FSM state enum;
  - an lsu_req_t struct {inst, pc, addr, data};
  - a wb_out_t struct {rd, data}.
- Sub-module pyrm_wb_dcache_dual: synchronous 2-line read (idx, idx+1 with wrap), per-line write enables, 1-cycle read latency.

Test Plan:
- ADDI result: data_pyri=0x1234, rd=5 -> decode and debug valid the next cycle with addr 5, data 0x1234; no branch output.
- SD 0x1122334455667788 at 0x10, then LD at 0x10 -> load returns 0x1122334455667788, 2 cycles after acceptance.
- SW 0xDEADBEEF at 0x1E (crosses line), then LW at 0x1E -> 0xFFFFFFFFDEADBEEF; LWU -> 0x00000000DEADBEEF. Line 0x18 bytes 6-7 and line 0x20 bytes 0-1 are modified.
- Backpressure:
  - debug retry held for 3 cycles while decode accepts immediately -> decode valid drops after 1 cycle; debug holds stable;
  - in_retry_pyro=1 until debug accepts;
  - the next bundle is accepted on the debug transfer cycle.
- Wrap: SD at byte address (2^DC_IDX_W)*8-4 -> the upper 4 bytes land in line 0; read back matches. With the trap macro, the same access raises misalign_trap_pyro with the correct pc.
- Reset asserted during MEM_WR of SD 0xFF.. at 0x40 -> a following LD of 0x40 returns the prior contents; all valids are 0 in the cycle after reset.
